commit_window_unit: RTL and testbench

COMMIT_WINDOW_UNIT -- requirements
Module: commit_window_unit

---
 rtl/commit_window_unit.sv | 147 ++++++++++++++
 tb/tb_commit_window_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_window_unit.sv
// Active-list commit window: tracks head/tail of the in-order active list and
// retires up to COMMIT_WINDOW_SIZE completed entries per cycle (one store max).
module commit_window_unit #(
    parameter int ACTIVE_LIST_SIZE   = 64,
    parameter int COMMIT_WINDOW_SIZE = 4,
    parameter int LOAD_STORE_SIZE    = 16,
    parameter int BRANCH_NUM         = 8,
    localparam int AL_IDX = $clog2(ACTIVE_LIST_SIZE),
    localparam int CW_IDX = $clog2(COMMIT_WINDOW_SIZE),
    localparam int LS_IDX = $clog2(LOAD_STORE_SIZE),
    localparam int BR_IDX = $clog2(BRANCH_NUM)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alloc_valid,
    input  logic                          alloc_is_load,
    input  logic                          alloc_is_store,
    input  logic                          alloc_is_branch,
    input  logic                          ready_set_valid,
    input  logic [AL_IDX-1:0]             ready_set_id,
    input  logic                          store_port_ready,
    input  logic                          flush,
    input  logic [AL_IDX:0]               flush_tail,
    output logic                          commit_valid,
    output logic [CW_IDX-1:0]             last_valid_commit_idx,
    output logic [COMMIT_WINDOW_SIZE-1:0] load_valid,
    output logic [COMMIT_WINDOW_SIZE-1:0] store_valid,
    output logic [COMMIT_WINDOW_SIZE-1:0] branch_valid,
    output logic [AL_IDX-1:0]             oldest_inst_pointer,
    output logic [LS_IDX-1:0]             load_commit_pointer,
    output logic [LS_IDX-1:0]             store_commit_pointer,
    output logic [BR_IDX-1:0]             branch_read_pointer,
    output logic [AL_IDX:0]               count,
    output logic                          full
);

    logic [AL_IDX:0]                 head;
    logic [AL_IDX:0]                 tail;
    logic [ACTIVE_LIST_SIZE-1:0]     ready;
    logic [ACTIVE_LIST_SIZE-1:0]     is_load;
    logic [ACTIVE_LIST_SIZE-1:0]     is_store;
    logic [ACTIVE_LIST_SIZE-1:0]     is_branch;
    logic [AL_IDX-1:0]               slot_idx [COMMIT_WINDOW_SIZE];
    logic [COMMIT_WINDOW_SIZE-1:0]   slot_commit;
    logic [CW_IDX:0]                 commit_num;
    logic [CW_IDX:0]                 load_num;
    logic [CW_IDX:0]                 store_num;
    logic [CW_IDX:0]                 branch_num;
    logic                            do_alloc;

    assign count               = tail - head;
    assign full                = (count == (AL_IDX+1)'(ACTIVE_LIST_SIZE));
    assign do_alloc            = alloc_valid && !full && !flush;
    assign oldest_inst_pointer = head[AL_IDX-1:0];
    assign commit_valid        = slot_commit[0];

    always_comb begin
        for (int unsigned i = 0; i < COMMIT_WINDOW_SIZE; i++) begin
            slot_idx[i] = head[AL_IDX-1:0] + AL_IDX'(i);
        end
    end

    // Commits form a contiguous prefix of the window; only the first store may drain.
    always_comb begin
        logic ok;
        logic prefix_ok;
        logic store_seen;
        ok          = 1'b0;
        prefix_ok   = 1'b1;
        store_seen  = 1'b0;
        slot_commit = '0;
        for (int unsigned i = 0; i < COMMIT_WINDOW_SIZE; i++) begin
            ok = prefix_ok && ((AL_IDX+1)'(i) < count) && ready[slot_idx[i]];
            if (is_store[slot_idx[i]]) begin
                ok = ok && !store_seen && store_port_ready;
            end
            store_seen     = store_seen | is_store[slot_idx[i]];
            slot_commit[i] = ok;
            prefix_ok      = ok;
        end
    end

    always_comb begin
        commit_num            = '0;
        load_num              = '0;
        store_num             = '0;
        branch_num            = '0;
        last_valid_commit_idx = '0;
        load_valid            = '0;
        store_valid           = '0;
        branch_valid          = '0;
        for (int unsigned i = 0; i < COMMIT_WINDOW_SIZE; i++) begin
            load_valid[i]   = slot_commit[i] & is_load[slot_idx[i]];
            store_valid[i]  = slot_commit[i] & is_store[slot_idx[i]];
            branch_valid[i] = slot_commit[i] & is_branch[slot_idx[i]];
            load_num        = load_num + (CW_IDX+1)'(load_valid[i]);
            store_num       = store_num + (CW_IDX+1)'(store_valid[i]);
            branch_num      = branch_num + (CW_IDX+1)'(branch_valid[i]);
            if (slot_commit[i]) begin
                commit_num            = commit_num + (CW_IDX+1)'(1);
                last_valid_commit_idx = CW_IDX'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            head                 <= '0;
            tail                 <= '0;
            ready                <= '0;
            is_load              <= '0;
            is_store             <= '0;
            is_branch            <= '0;
            load_commit_pointer  <= '0;
            store_commit_pointer <= '0;
            branch_read_pointer  <= '0;
        end else begin
            head                 <= head + (AL_IDX+1)'(commit_num);
            load_commit_pointer  <= load_commit_pointer + LS_IDX'(load_num);
            store_commit_pointer <= store_commit_pointer + LS_IDX'(store_num);
            branch_read_pointer  <= branch_read_pointer + BR_IDX'(branch_num);

            if (flush) begin
                tail <= flush_tail;
            end else if (do_alloc) begin
                tail <= tail + (AL_IDX+1)'(1);
            end

            // Later assignments win: a fresh allocation always starts not-ready.
            if (ready_set_valid) begin
                ready[ready_set_id] <= 1'b1;
            end
            for (int unsigned i = 0; i < COMMIT_WINDOW_SIZE; i++) begin
                if (slot_commit[i]) begin
                    ready[slot_idx[i]] <= 1'b0;
                end
            end
            if (do_alloc) begin
                ready[tail[AL_IDX-1:0]]     <= 1'b0;
                is_load[tail[AL_IDX-1:0]]   <= alloc_is_load;
                is_store[tail[AL_IDX-1:0]]  <= alloc_is_store;
                is_branch[tail[AL_IDX-1:0]] <= alloc_is_branch;
            end
        end
    end

endmodule

// File: tb/tb_commit_window_unit.sv
// Directed bench for commit_window_unit: a vector table for the basic commit
// patterns plus hand sequences for full, wrap-around and flush corners.
module tb_commit_window_unit;

    logic       clk;
    logic       rst_n;
    logic       alloc_valid, alloc_is_load, alloc_is_store, alloc_is_branch;
    logic       ready_set_valid;
    logic [5:0] ready_set_id;
    logic       store_port_ready;
    logic       flush;
    logic [6:0] flush_tail;
    logic       commit_valid;
    logic [1:0] last_valid_commit_idx;
    logic [3:0] load_valid, store_valid, branch_valid;
    logic [5:0] oldest_inst_pointer;
    logic [3:0] load_commit_pointer, store_commit_pointer;
    logic [2:0] branch_read_pointer;
    logic [6:0] count;
    logic       full;

    int checks = 0;
    int errors = 0;

    commit_window_unit #(
        .ACTIVE_LIST_SIZE  (64),
        .COMMIT_WINDOW_SIZE(4),
        .LOAD_STORE_SIZE   (16),
        .BRANCH_NUM        (8)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .alloc_valid          (alloc_valid),
        .alloc_is_load        (alloc_is_load),
        .alloc_is_store       (alloc_is_store),
        .alloc_is_branch      (alloc_is_branch),
        .ready_set_valid      (ready_set_valid),
        .ready_set_id         (ready_set_id),
        .store_port_ready     (store_port_ready),
        .flush                (flush),
        .flush_tail           (flush_tail),
        .commit_valid         (commit_valid),
        .last_valid_commit_idx(last_valid_commit_idx),
        .load_valid           (load_valid),
        .store_valid          (store_valid),
        .branch_valid         (branch_valid),
        .oldest_inst_pointer  (oldest_inst_pointer),
        .load_commit_pointer  (load_commit_pointer),
        .store_commit_pointer (store_commit_pointer),
        .branch_read_pointer  (branch_read_pointer),
        .count                (count),
        .full                 (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       a, ld, st, br, rv;
        int       rid;
        bit       spr;
        bit       cv;
        int       last;
        bit [3:0] lv, sv, bv;
        int       cnt, old, ldp, stp, brp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit a, ld, st, br, rv, input int rid, input bit spr,
                       input bit cv, input int last, input bit [3:0] lv, sv, bv,
                       input int cnt, old, ldp, stp, brp);
        vec_t v;
        v.a = a; v.ld = ld; v.st = st; v.br = br; v.rv = rv; v.rid = rid; v.spr = spr;
        v.cv = cv; v.last = last; v.lv = lv; v.sv = sv; v.bv = bv;
        v.cnt = cnt; v.old = old; v.ldp = ldp; v.stp = stp; v.brp = brp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input bit a, ld, st, br, rv, input int rid, input bit spr,
                         input bit fl, input int ft);
        @(negedge clk);
        alloc_valid      = a;
        alloc_is_load    = ld;
        alloc_is_store   = st;
        alloc_is_branch  = br;
        ready_set_valid  = rv;
        ready_set_id     = 6'(rid);
        store_port_ready = spr;
        flush            = fl;
        flush_tail       = 7'(ft);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic alloc_alu();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic rdy(input int id);
        drive(0, 0, 0, 0, 1, id, 1, 0, 0);
    endtask

    // Reset is held while alloc, ready_set and flush are all asserted.
    task automatic do_reset();
        rst_n = 1'b1;
        drive(1, 1, 1, 1, 1, 5, 1, 1, 7);
        drive(1, 1, 1, 1, 1, 5, 1, 1, 7);
        idle();
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        alloc_valid = 0; alloc_is_load = 0; alloc_is_store = 0; alloc_is_branch = 0;
        ready_set_valid = 0; ready_set_id = '0; store_port_ready = 1;
        flush = 0; flush_tail = '0;

        // Four ALU ops, readied 3,2,1 then 0: nothing commits until 0, then all four.
        add(1,0,0,0, 0,0,1, 0,0,4'b0000,4'b0000,4'b0000, 0,0,0,0,0);
        add(1,0,0,0, 0,0,1, 0,0,4'b0000,4'b0000,4'b0000, 1,0,0,0,0);
        add(1,0,0,0, 0,0,1, 0,0,4'b0000,4'b0000,4'b0000, 2,0,0,0,0);
        add(1,0,0,0, 0,0,1, 0,0,4'b0000,4'b0000,4'b0000, 3,0,0,0,0);
        add(0,0,0,0, 1,3,1, 0,0,4'b0000,4'b0000,4'b0000, 4,0,0,0,0);
        add(0,0,0,0, 1,2,1, 0,0,4'b0000,4'b0000,4'b0000, 4,0,0,0,0);
        add(0,0,0,0, 1,1,1, 0,0,4'b0000,4'b0000,4'b0000, 4,0,0,0,0);
        add(0,0,0,0, 1,0,1, 0,0,4'b0000,4'b0000,4'b0000, 4,0,0,0,0);
        add(0,0,0,0, 0,0,1, 1,3,4'b0000,4'b0000,4'b0000, 4,0,0,0,0);
        add(0,0,0,0, 0,0,1, 0,0,4'b0000,4'b0000,4'b0000, 0,4,0,0,0);
        // load, store, store, branch at entries 4..7
        add(1,1,0,0, 0,0,1, 0,0,4'b0000,4'b0000,4'b0000, 0,4,0,0,0);
        add(1,0,1,0, 0,0,1, 0,0,4'b0000,4'b0000,4'b0000, 1,4,0,0,0);
        add(1,0,1,0, 0,0,1, 0,0,4'b0000,4'b0000,4'b0000, 2,4,0,0,0);
        add(1,0,0,1, 0,0,1, 0,0,4'b0000,4'b0000,4'b0000, 3,4,0,0,0);
        add(0,0,0,0, 1,7,1, 0,0,4'b0000,4'b0000,4'b0000, 4,4,0,0,0);
        add(0,0,0,0, 1,6,1, 0,0,4'b0000,4'b0000,4'b0000, 4,4,0,0,0);
        add(0,0,0,0, 1,5,1, 0,0,4'b0000,4'b0000,4'b0000, 4,4,0,0,0);
        add(0,0,0,0, 1,4,1, 0,0,4'b0000,4'b0000,4'b0000, 4,4,0,0,0);
        add(0,0,0,0, 0,0,1, 1,1,4'b0001,4'b0010,4'b0000, 4,4,0,0,0);
        add(0,0,0,0, 0,0,0, 0,0,4'b0000,4'b0000,4'b0000, 2,6,1,1,0);
        add(0,0,0,0, 0,0,1, 1,1,4'b0000,4'b0001,4'b0010, 2,6,1,1,0);
        add(0,0,0,0, 0,0,1, 0,0,4'b0000,4'b0000,4'b0000, 0,8,1,2,1);

        do_reset();
        foreach (vecs[k]) begin
            drive(vecs[k].a, vecs[k].ld, vecs[k].st, vecs[k].br, vecs[k].rv,
                  vecs[k].rid, vecs[k].spr, 0, 0);
            chk($sformatf("v%0d_commit_valid", k), int'(commit_valid), int'(vecs[k].cv));
            chk($sformatf("v%0d_last_idx", k), int'(last_valid_commit_idx), vecs[k].last);
            chk($sformatf("v%0d_load_valid", k), int'(load_valid), int'(vecs[k].lv));
            chk($sformatf("v%0d_store_valid", k), int'(store_valid), int'(vecs[k].sv));
            chk($sformatf("v%0d_branch_valid", k), int'(branch_valid), int'(vecs[k].bv));
            chk($sformatf("v%0d_count", k), int'(count), vecs[k].cnt);
            chk($sformatf("v%0d_full", k), int'(full), 0);
            chk($sformatf("v%0d_oldest", k), int'(oldest_inst_pointer), vecs[k].old);
            chk($sformatf("v%0d_load_ptr", k), int'(load_commit_pointer), vecs[k].ldp);
            chk($sformatf("v%0d_store_ptr", k), int'(store_commit_pointer), vecs[k].stp);
            chk($sformatf("v%0d_branch_ptr", k), int'(branch_read_pointer), vecs[k].brp);
        end

        // Full list: 65th alloc dropped, two commits free two slots.
        do_reset();
        for (int i = 0; i < 64; i++) alloc_alu();
        alloc_alu();
        chk("full_count", int'(count), 64);
        chk("full_flag", int'(full), 1);
        rdy(1);
        chk("full_after_extra_alloc", int'(count), 64);
        rdy(0);
        chk("full_no_commit", int'(commit_valid), 0);
        idle();
        chk("full_commit_valid", int'(commit_valid), 1);
        chk("full_commit_last", int'(last_valid_commit_idx), 1);
        idle();
        chk("full_drain_count", int'(count), 62);
        chk("full_drain_flag", int'(full), 0);
        chk("full_drain_oldest", int'(oldest_inst_pointer), 2);

        // Wrap-around: bring head to 62, then commit entries 62,63,0,1 together.
        do_reset();
        for (int i = 0; i < 62; i++) alloc_alu();
        for (int i = 0; i < 62; i++) rdy(i);
        idle();
        idle();
        chk("wrap_pre_count", int'(count), 0);
        chk("wrap_pre_oldest", int'(oldest_inst_pointer), 62);
        for (int i = 0; i < 4; i++) alloc_alu();
        rdy(1);
        chk("wrap_alloc_count", int'(count), 4);
        rdy(0);
        rdy(63);
        rdy(62);
        chk("wrap_wait_commit", int'(commit_valid), 0);
        idle();
        chk("wrap_commit_valid", int'(commit_valid), 1);
        chk("wrap_commit_last", int'(last_valid_commit_idx), 3);
        idle();
        chk("wrap_post_count", int'(count), 0);
        chk("wrap_post_oldest", int'(oldest_inst_pointer), 2);

        // Flush with concurrent alloc and commit: head=2, tail=10 -> flush_tail=5.
        do_reset();
        for (int i = 0; i < 10; i++) alloc_alu();
        rdy(0);
        rdy(1);
        chk("flush_c0_valid", int'(commit_valid), 1);
        idle();
        rdy(2);
        chk("flush_pre_count", int'(count), 8);
        chk("flush_pre_oldest", int'(oldest_inst_pointer), 2);
        drive(1, 0, 0, 0, 0, 0, 1, 1, 5);
        chk("flush_commit_valid", int'(commit_valid), 1);
        chk("flush_commit_last", int'(last_valid_commit_idx), 0);
        idle();
        chk("flush_post_count", int'(count), 2);
        chk("flush_post_oldest", int'(oldest_inst_pointer), 3);
        chk("flush_post_commit", int'(commit_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
